// File: rtl/alt_temp_sense_ctrl_pkg.sv
// Shared types and default constants for the on-die temperature sense controller
// and its saturation helper.
package alt_temp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CONV,
        PAUSE
    } state_t;

    localparam int DEF_RAW_OFFSET     = 128;
    localparam int DEF_TIMEOUT_CYCLES = 65535;
    localparam int DEF_POLL_INTERVAL  = 1000;

    // Sum of 2^log2_samples raw readings fits without overflow in this many bits.
    function automatic int acc_width(input int raw_width, input int log2_samples);
        return raw_width + log2_samples;
    endfunction

endpackage

// File: rtl/alt_temp_sense_ctrl_if.sv
// Conversion handshake between the sense controller (master) and the TSD macro (slave).
interface alt_temp_sense_ctrl_if #(
    parameter int RAW_WIDTH = 10
);
    logic                 tsd_start;
    logic                 tsd_done;
    logic [RAW_WIDTH-1:0] tsd_data;

    modport master (output tsd_start, input tsd_done, input tsd_data);
    modport slave  (input tsd_start, output tsd_done, output tsd_data);
endinterface

// File: rtl/alt_temp_sense_ctrl_sat.sv
// Turns a sample sum into an average, removes the 0 C raw offset and clamps the
// result into an unsigned WIDTH-bit Celsius word.
module alt_temp_sat_sub
    import alt_temp_pkg::*;
#(
    parameter int ACC_WIDTH    = 13,
    parameter int LOG2_SAMPLES = 3,
    parameter int RAW_OFFSET   = DEF_RAW_OFFSET,
    parameter int WIDTH        = 8
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [WIDTH-1:0]     celsius
);
    localparam int AVG_W = ACC_WIDTH - LOG2_SAMPLES;
    // One spare bit so the clamp compare works whichever of AVG_W/WIDTH is wider.
    localparam int DW = ((AVG_W > WIDTH) ? AVG_W : WIDTH) + 1;
    localparam logic [DW-1:0] OFFSET  = DW'(RAW_OFFSET);
    localparam logic [DW-1:0] SAT_MAX = DW'({WIDTH{1'b1}});

    logic [DW-1:0] avg;
    logic [DW-1:0] diff;

    always_comb begin
        avg  = DW'(acc >> LOG2_SAMPLES);
        diff = avg - OFFSET;
        if (avg < OFFSET)
            celsius = '0;
        else if (diff > SAT_MAX)
            celsius = '1;
        else
            celsius = diff[WIDTH-1:0];
    end

endmodule

// File: rtl/alt_temp_sense_ctrl.sv
// Polls the temperature sense diode, averages a burst of readings and publishes a
// saturated Celsius word with a one-cycle valid strobe.
module alt_temp_sense_ctrl
    import alt_temp_pkg::*;
#(
    parameter int RAW_WIDTH      = 10,
    parameter int WIDTH          = 8,
    parameter int LOG2_SAMPLES   = 3,
    parameter int RAW_OFFSET     = DEF_RAW_OFFSET,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int POLL_INTERVAL  = DEF_POLL_INTERVAL
) (
    input  logic                  clk,
    input  logic                  sclr,
    input  logic                  enable,
    alt_temp_sense_ctrl_if.master tsd,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic                  timeout_err
);
    localparam int ACC_W   = acc_width(RAW_WIDTH, LOG2_SAMPLES);
    localparam int CNT_W   = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
    localparam int TMR_MAX = (TIMEOUT_CYCLES > POLL_INTERVAL) ? TIMEOUT_CYCLES : POLL_INTERVAL;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE  = CNT_W'((1 << LOG2_SAMPLES) - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] PAUSE_LAST   = TMR_W'(POLL_INTERVAL - 1);

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] sample_cnt, sample_cnt_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic             start_q, start_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             valid_nxt;
    logic             terr_nxt;
    logic [WIDTH-1:0] celsius;
    logic             requesting;
    logic             accept;
    logic             expired;
    logic             last_sample;

    // tsd_done only counts while a request is actually outstanding.
    assign requesting  = (state == WAIT) && start_q;
    assign accept      = requesting && tsd.tsd_done;
    assign expired     = requesting && !tsd.tsd_done && (timer == TIMEOUT_LAST);
    assign last_sample = (sample_cnt == LAST_SAMPLE);
    assign tsd.tsd_start = start_q;

    alt_temp_sat_sub #(
        .ACC_WIDTH   (ACC_W),
        .LOG2_SAMPLES(LOG2_SAMPLES),
        .RAW_OFFSET  (RAW_OFFSET),
        .WIDTH       (WIDTH)
    ) u_sat (
        .acc    (acc),
        .celsius(celsius)
    );

    always_ff @(posedge clk) begin
        if (sclr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = WAIT;
            WAIT: begin
                if (accept && last_sample)
                    state_nxt = CONV;
                else if (expired)
                    state_nxt = PAUSE;
            end
            CONV:    state_nxt = PAUSE;
            PAUSE: begin
                if (!enable)
                    state_nxt = IDLE;
                else if (timer == PAUSE_LAST)
                    state_nxt = WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of every registered output and datapath register. The single
    // timer serves as the conversion timeout in WAIT and the poll spacing in PAUSE.
    always_comb begin
        start_nxt      = start_q;
        timer_nxt      = timer;
        sample_cnt_nxt = sample_cnt;
        acc_nxt        = acc;
        dout_nxt       = dout;
        valid_nxt      = 1'b0;
        terr_nxt       = timeout_err;
        case (state)
            IDLE: begin
                timer_nxt      = '0;
                sample_cnt_nxt = '0;
                acc_nxt        = '0;
                start_nxt      = enable;
            end
            WAIT: begin
                if (!start_q) begin
                    // Gap after a sample: a level-style done must drop before re-requesting.
                    start_nxt = !tsd.tsd_done;
                    timer_nxt = '0;
                end else if (accept) begin
                    acc_nxt   = acc + ACC_W'(tsd.tsd_data);
                    start_nxt = 1'b0;
                    timer_nxt = '0;
                    if (!last_sample)
                        sample_cnt_nxt = sample_cnt + 1'b1;
                end else if (expired) begin
                    terr_nxt       = 1'b1;
                    start_nxt      = 1'b0;
                    timer_nxt      = '0;
                    acc_nxt        = '0;
                    sample_cnt_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            CONV: begin
                dout_nxt  = celsius;
                valid_nxt = 1'b1;
                timer_nxt = '0;
            end
            PAUSE: begin
                start_nxt = 1'b0;
                if (state_nxt == WAIT) begin
                    start_nxt      = 1'b1;
                    timer_nxt      = '0;
                    acc_nxt        = '0;
                    sample_cnt_nxt = '0;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                start_nxt = 1'b0;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            start_q     <= 1'b0;
            timer       <= '0;
            sample_cnt  <= '0;
            acc         <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            start_q     <= start_nxt;
            timer       <= timer_nxt;
            sample_cnt  <= sample_cnt_nxt;
            acc         <= acc_nxt;
            dout        <= dout_nxt;
            dout_valid  <= valid_nxt;
            timeout_err <= terr_nxt;
        end
    end

endmodule

// File: tb/tb_alt_temp_sense_ctrl.sv
// Directed bench for alt_temp_sense_ctrl: a behavioural TSD responder plus a
// negedge monitor feed per-scenario tasks with hand-computed expectations.
module tb_alt_temp_sense_ctrl;
    import alt_temp_pkg::*;

    localparam int RAW_WIDTH      = 10;
    localparam int WIDTH          = 8;
    localparam int LOG2_SAMPLES   = 3;
    localparam int RAW_OFFSET     = 128;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int POLL_INTERVAL  = 20;

    logic             clk;
    logic             sclr;
    logic             enable;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             timeout_err;

    alt_temp_sense_ctrl_if #(.RAW_WIDTH(RAW_WIDTH)) tsd_bus ();

    alt_temp_sense_ctrl #(
        .RAW_WIDTH     (RAW_WIDTH),
        .WIDTH         (WIDTH),
        .LOG2_SAMPLES  (LOG2_SAMPLES),
        .RAW_OFFSET    (RAW_OFFSET),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .POLL_INTERVAL (POLL_INTERVAL)
    ) dut (
        .clk        (clk),
        .sclr       (sclr),
        .enable     (enable),
        .tsd        (tsd_bus),
        .dout       (dout),
        .dout_valid (dout_valid),
        .timeout_err(timeout_err)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    int sample_tbl [8];
    int resp_delay   = 5;
    int hold_len     = 1;
    int resp_idx     = 0;
    int withhold_idx = -1;

    logic start_q = 1'b0;
    int   rise_cnt = 0;
    int   valid_cnt = 0;
    int   start_viol = 0;
    int   last_rise_cyc = 0;
    int   last_fall_cyc = 0;
    int   last_accept_cyc = 0;
    int   last_valid_cyc = 0;
    int   gaps [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // TSD model: answers resp_delay cycles after a request, holds done for hold_len cycles.
    initial begin
        tsd_bus.tsd_done = 1'b0;
        tsd_bus.tsd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (tsd_bus.tsd_start) begin : respond
                bit aborted;
                aborted = 1'b0;
                for (int k = 0; k < resp_delay - 1; k++) begin
                    @(posedge clk); #1;
                    if (!tsd_bus.tsd_start) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted && resp_idx == withhold_idx) begin
                    while (tsd_bus.tsd_start) begin
                        @(posedge clk); #1;
                    end
                    withhold_idx = -1;
                    resp_idx++;
                end else if (!aborted) begin
                    tsd_bus.tsd_data = RAW_WIDTH'(sample_tbl[resp_idx % 8]);
                    tsd_bus.tsd_done = 1'b1;
                    repeat (hold_len) begin
                        @(posedge clk); #1;
                    end
                    tsd_bus.tsd_done = 1'b0;
                    tsd_bus.tsd_data = '0;
                    resp_idx++;
                end
            end
        end
    end

    // Cycle-stamps request edges, accepted samples and result strobes.
    initial forever begin
        @(negedge clk);
        if (tsd_bus.tsd_start && !start_q) begin
            rise_cnt++;
            gaps.push_back(cyc - last_fall_cyc);
            last_rise_cyc = cyc;
            if (tsd_bus.tsd_done) start_viol++;
        end
        if (!tsd_bus.tsd_start && start_q) last_fall_cyc = cyc;
        if (tsd_bus.tsd_start && tsd_bus.tsd_done) last_accept_cyc = cyc;
        if (dout_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        start_q = tsd_bus.tsd_start;
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic fill_tbl(input int v);
        for (int i = 0; i < 8; i++) sample_tbl[i] = v;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (dout_valid) seen = 1'b1;
        end
    endtask

    task automatic fresh_start(input int d, input int h);
        enable = 1'b0;
        sclr   = 1'b1;
        repeat (14) tick();
        sclr         = 1'b0;
        resp_delay   = d;
        hold_len     = h;
        resp_idx     = 0;
        withhold_idx = -1;
        valid_cnt    = 0;
        rise_cnt     = 0;
        start_viol   = 0;
        gaps.delete();
        tick();
    endtask

    task automatic test_reset();
        sclr   = 1'b1;
        enable = 1'b0;
        fill_tbl(153);
        repeat (3) tick();
        vec_cnt++; if (tsd_bus.tsd_start !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_tsd_start: got %b want 0", tsd_bus.tsd_start); end
        vec_cnt++; if (dout !== 8'd0) begin err_cnt++; $display("[TB] FAIL reset_dout: got %0d want 0", dout); end
        vec_cnt++; if (dout_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_dout_valid: got %b want 0", dout_valid); end
        vec_cnt++; if (timeout_err !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_timeout_err: got %b want 0", timeout_err); end
        vec_cnt++; if (dut.state !== IDLE) begin err_cnt++; $display("[TB] FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
        sclr = 1'b0;
        tick();
    endtask

    task automatic test_avg_const();
        bit seen;
        int gap1;
        fresh_start(5, 1);
        fill_tbl(153);
        enable = 1'b1;
        wait_valid(400, seen);
        gap1 = (gaps.size() > 1) ? gaps[1] : -1;
        vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("[TB] FAIL const_valid_seen: got %b want 1", seen); end
        vec_cnt++; if (dout !== 8'd25) begin err_cnt++; $display("[TB] FAIL const_dout: got %0d want 25", dout); end
        vec_cnt++; if (last_valid_cyc - last_accept_cyc != 2) begin err_cnt++; $display("[TB] FAIL const_latency: got %0d want 2", last_valid_cyc - last_accept_cyc); end
        vec_cnt++; if (rise_cnt != 8) begin err_cnt++; $display("[TB] FAIL const_requests: got %0d want 8", rise_cnt); end
        vec_cnt++; if (gap1 != 1) begin err_cnt++; $display("[TB] FAIL const_start_gap: got %0d want 1", gap1); end
        tick();
        vec_cnt++; if (dout_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL const_valid_pulse: got %b want 0", dout_valid); end
        vec_cnt++; if (valid_cnt != 1) begin err_cnt++; $display("[TB] FAIL const_valid_count: got %0d want 1", valid_cnt); end
    endtask

    task automatic test_avg_ramp();
        bit seen;
        int r0;
        int v;
        fresh_start(5, 1);
        for (int i = 0; i < 8; i++) sample_tbl[i] = 150 + i;
        enable = 1'b1;
        wait_valid(400, seen);
        vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("[TB] FAIL ramp_valid_seen: got %b want 1", seen); end
        vec_cnt++; if (dout !== 8'd25) begin err_cnt++; $display("[TB] FAIL ramp_dout: got %0d want 25", dout); end
        v  = last_valid_cyc;
        r0 = rise_cnt;
        for (int i = 0; i < 100 && rise_cnt == r0; i++) tick();
        vec_cnt++; if (last_rise_cyc - v != POLL_INTERVAL) begin err_cnt++; $display("[TB] FAIL ramp_poll_spacing: got %0d want %0d", last_rise_cyc - v, POLL_INTERVAL); end
    endtask

    task automatic test_clamp();
        bit seen;
        fresh_start(5, 1);
        fill_tbl(1000);
        enable = 1'b1;
        wait_valid(400, seen);
        vec_cnt++; if (seen !== 1'b1 || dout !== 8'd255) begin err_cnt++; $display("[TB] FAIL clamp_high: got %0d (seen %b) want 255", dout, seen); end
        fill_tbl(100);
        wait_valid(400, seen);
        vec_cnt++; if (seen !== 1'b1 || dout !== 8'd0) begin err_cnt++; $display("[TB] FAIL clamp_low: got %0d (seen %b) want 0", dout, seen); end
    endtask

    task automatic test_timeout();
        bit seen;
        int vsnap;
        fresh_start(5, 1);
        fill_tbl(153);
        enable = 1'b1;
        wait_valid(400, seen);
        vec_cnt++; if (seen !== 1'b1 || dout !== 8'd25) begin err_cnt++; $display("[TB] FAIL timeout_pre_dout: got %0d (seen %b) want 25", dout, seen); end
        fill_tbl(140);
        withhold_idx = resp_idx + 3;
        vsnap = valid_cnt;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (timeout_err === 1'b1) seen = 1'b1;
        end
        vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("[TB] FAIL timeout_flag: got %b want 1", timeout_err); end
        vec_cnt++; if (last_fall_cyc - last_rise_cyc != TIMEOUT_CYCLES) begin err_cnt++; $display("[TB] FAIL timeout_start_len: got %0d want %0d", last_fall_cyc - last_rise_cyc, TIMEOUT_CYCLES); end
        vec_cnt++; if (tsd_bus.tsd_start !== 1'b0) begin err_cnt++; $display("[TB] FAIL timeout_start_low: got %b want 0", tsd_bus.tsd_start); end
        vec_cnt++; if (dout !== 8'd25) begin err_cnt++; $display("[TB] FAIL timeout_dout_held: got %0d want 25", dout); end
        vec_cnt++; if (valid_cnt != vsnap) begin err_cnt++; $display("[TB] FAIL timeout_no_valid: got %0d want %0d", valid_cnt, vsnap); end
        wait_valid(400, seen);
        vec_cnt++; if (seen !== 1'b1 || dout !== 8'd12) begin err_cnt++; $display("[TB] FAIL timeout_next_dout: got %0d (seen %b) want 12", dout, seen); end
        vec_cnt++; if (timeout_err !== 1'b1) begin err_cnt++; $display("[TB] FAIL timeout_sticky: got %b want 1", timeout_err); end
        vec_cnt++; if (valid_cnt - vsnap != 1) begin err_cnt++; $display("[TB] FAIL timeout_valid_count: got %0d want 1", valid_cnt - vsnap); end
    endtask

    task automatic test_level_done();
        bit seen;
        int gap1;
        fresh_start(5, 10);
        sample_tbl[0] = 200;
        for (int i = 1; i < 8; i++) sample_tbl[i] = 130;
        enable = 1'b1;
        wait_valid(1000, seen);
        gap1 = (gaps.size() > 1) ? gaps[1] : -1;
        vec_cnt++; if (seen !== 1'b1 || dout !== 8'd10) begin err_cnt++; $display("[TB] FAIL level_dout: got %0d (seen %b) want 10", dout, seen); end
        vec_cnt++; if (rise_cnt != 8) begin err_cnt++; $display("[TB] FAIL level_requests: got %0d want 8", rise_cnt); end
        vec_cnt++; if (start_viol != 0) begin err_cnt++; $display("[TB] FAIL level_start_while_done: got %0d want 0", start_viol); end
        vec_cnt++; if (gap1 != 10) begin err_cnt++; $display("[TB] FAIL level_start_gap: got %0d want 10", gap1); end
    endtask

    // Runs straight on from test_timeout so timeout_err and dout are non-zero when sclr hits.
    task automatic test_back_to_back();
        bit seen;
        int r0;
        int r1;
        fill_tbl(153);
        wait_valid(400, seen);
        r0 = rise_cnt;
        for (int i = 0; i < 200 && rise_cnt < r0 + 3; i++) tick();
        tick();
        vec_cnt++; if (dut.state !== WAIT || timeout_err !== 1'b1) begin err_cnt++; $display("[TB] FAIL sclr_pre_state: got state %0d err %b want %0d and 1", dut.state, timeout_err, WAIT); end
        sclr = 1'b1;
        tick();
        vec_cnt++; if (tsd_bus.tsd_start !== 1'b0) begin err_cnt++; $display("[TB] FAIL sclr_tsd_start: got %b want 0", tsd_bus.tsd_start); end
        vec_cnt++; if (dout !== 8'd0) begin err_cnt++; $display("[TB] FAIL sclr_dout: got %0d want 0", dout); end
        vec_cnt++; if (dout_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL sclr_dout_valid: got %b want 0", dout_valid); end
        vec_cnt++; if (timeout_err !== 1'b0) begin err_cnt++; $display("[TB] FAIL sclr_timeout_err: got %b want 0", timeout_err); end
        vec_cnt++; if (dut.state !== IDLE) begin err_cnt++; $display("[TB] FAIL sclr_state: got %0d want %0d", dut.state, IDLE); end
        sclr = 1'b0;
        r1 = rise_cnt;
        wait_valid(400, seen);
        vec_cnt++; if (seen !== 1'b1 || dout !== 8'd25) begin err_cnt++; $display("[TB] FAIL sclr_restart_dout: got %0d (seen %b) want 25", dout, seen); end
        vec_cnt++; if (rise_cnt - r1 != 8) begin err_cnt++; $display("[TB] FAIL sclr_restart_requests: got %0d want 8", rise_cnt - r1); end
        enable = 1'b0;
        tick();
        vec_cnt++; if (dut.state !== IDLE) begin err_cnt++; $display("[TB] FAIL disable_state: got %0d want %0d", dut.state, IDLE); end
        r1 = rise_cnt;
        repeat (40) tick();
        vec_cnt++; if (tsd_bus.tsd_start !== 1'b0 || rise_cnt != r1) begin err_cnt++; $display("[TB] FAIL disable_quiet: got start %b rises %0d want 0 and %0d", tsd_bus.tsd_start, rise_cnt, r1); end
    endtask

    initial begin
        sclr   = 1'b1;
        enable = 1'b0;
        test_reset();
        test_avg_const();
        test_avg_ramp();
        test_clamp();
        test_level_done();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
